mimo_tx_queue_scheduler: RTL and testbench
==========================================

Name: mimo_tx_queue_scheduler

Overview:
Arbitrates several host TX packet queues (short-hand FIFOs, header visible when pkt_waiting) onto the single MIMO FIFO reader. Grants one queue per packet, or per burst when the header opens a burst. Presents the granted queue to the reader as one virtual FIFO (pkt_waiting/fifodata in, rdreq/skip back). Sits between the per-queue TX RAMs and the reader in the tx_clock domain.

Parameters:
NUM_Q, 2, number of queues (2..4); index 0 is lowest.
LOCK_TIMEOUT, 4096, cycles a burst lock waits for the locked queue's next packet before forced release.

Ports:
tx_clock  in  1  clock
reset  in  1  synchronous, active-high; clock tx_clock
enable  in  1  permits new grants; does not abort a granted packet
prio_mask  in  NUM_Q  queues with strict priority over round-robin
q_pkt_waiting  in  NUM_Q  per-queue packet ready
q_fifodata  in  32*NUM_Q  per-queue data, queue k at [32k+31:32k]
q_rdreq  out  NUM_Q  rdreq routed to granted queue
q_skip  out  NUM_Q  skip routed to granted queue
rd_pkt_waiting  out  1  to reader pkt_waiting
rd_fifodata  out  32  to reader fifodata
rd_rdreq  in  1  from reader rdreq
rd_skip  in  1  from reader skip
grant  out  NUM_Q  one-hot granted queue, 0 when none
busy  out  1  state != IDLE
lock_abort  out  1  one-cycle pulse on lock timeout
pkt_count  out  16  packets completed (wraps 0xFFFF->0)

Behaviour:
- Reset: state IDLE, grant 0, busy 0, rd_pkt_waiting 0, lock_abort 0, pkt_count 0, lock 0, timer 0, last_grant = NUM_Q-1. q_rdreq/q_skip 0 and rd_fifodata 0 whenever grant = 0. Reset mid-packet drops grant the next cycle; no skip is issued.
- Routing (combinational): rd_fifodata = q_fifodata[sel]; q_rdreq[sel] = rd_rdreq; q_skip[sel] = rd_skip. Valid only in PEEK/ACTIVE; other bits 0.
- IDLE: when enable and any q_pkt_waiting, select and register sel/grant, then go to PEEK.
  - Selection: lowest-index waiting queue within prio_mask if any; otherwise round-robin, first waiting index after last_grant, cyclic.
- PEEK: 1 cycle. Latch sob = rd_fifodata[28], eob = rd_fifodata[27]. Set rd_pkt_waiting = 1. Go to ACTIVE.
- ACTIVE:
  - rd_pkt_waiting clears in the cycle after the first rd_rdreq = 1.
  - On rd_skip = 1: pkt_count++, last_grant = sel, go to RELEASE.
  - q_pkt_waiting[sel] falling in ACTIVE is ignored; only rd_skip ends the packet.
- RELEASE, lock update first:
  - sob & !eob sets lock; eob clears lock; sob = eob = 0 keeps lock.
  - Locked and q_pkt_waiting[sel]: timer = 0, go to PEEK on the same queue. enable and prio_mask are ignored while locked.
  - Locked and not waiting: timer++. When timer = LOCK_TIMEOUT-1: lock = 0, lock_abort pulse, grant 0, go to IDLE.
  - Unlocked: grant 0, go to IDLE.
- Latency:
  - Idle queue ready to rd_pkt_waiting: 2 cycles.
  - rd_skip to next locked packet's rd_pkt_waiting: 3 cycles.
  - rd_skip to new grant: 2 cycles (RELEASE, IDLE).
- rd_skip/rd_rdreq outside PEEK/ACTIVE: ignored, not routed.
- rd_skip and rd_rdreq in the same cycle: skip wins; rdreq is still routed.

Decomposition:
- Package mimo_tx_pkg: header bit constants (HDR_SOB = 28, HDR_EOB = 27, HDR_RSSI = 26, HDR_PAYLOAD 8:2), scheduler state encoding (IDLE, PEEK, ACTIVE, RELEASE).
- One combinational sub-module, tx_rr_prio_arbiter:
  - Inputs: request, prio_mask, last_grant.
  - Outputs: one-hot select plus valid.

Test Plan:
1. Q0 and Q1 both waiting, prio_mask = 0, last_grant = 1, single-packet headers (sob = eob = 1) -> Q0 granted first, then Q1, then Q0; pkt_count 1, 2, 3.
2. prio_mask = 2'b10, both waiting continuously -> Q1 granted every packet; Q0 starves until Q1 drops waiting.
3. Q0 headers sob = 1/eob = 0, then 0/0, then 0/1, with Q1 waiting throughout -> grant stays 01 for all three packets; Q1 granted only after the eob packet; 3 cycles from skip to rd_pkt_waiting between locked packets.
4. Q0 burst opened, no further Q0 packet, LOCK_TIMEOUT = 8 -> lock_abort pulses 8 cycles after entering RELEASE; the next grant goes to waiting Q1.
5. Reset asserted in ACTIVE with rd_rdreq high -> next cycle grant = 0, q_rdreq = 0, rd_pkt_waiting = 0, pkt_count = 0.
6. enable = 0 during an ACTIVE packet -> packet completes with skip routed; no new grant while enable = 0, even with queues waiting.

Source files
------------

// File: rtl/mimo_tx_queue_scheduler_pkg.sv
// Shared definitions for the MIMO TX queue scheduler.
//   HDR_*          bit positions inside the packet header word
//   sched_state_t  scheduler FSM states
//   lock_next()    burst-lock update from a packet's sob/eob flags
package mimo_tx_pkg;

    localparam int unsigned HDR_SOB         = 28;
    localparam int unsigned HDR_EOB         = 27;
    localparam int unsigned HDR_RSSI        = 26;
    localparam int unsigned HDR_PAYLOAD_MSB = 8;
    localparam int unsigned HDR_PAYLOAD_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        PEEK,
        ACTIVE,
        RELEASE
    } sched_state_t;

    // sob alone opens a burst, eob closes it, neither keeps the current lock.
    function automatic logic lock_next(input logic lock, input logic sob, input logic eob);
        if (sob && !eob) return 1'b1;
        if (eob)         return 1'b0;
        return lock;
    endfunction

endpackage

// File: rtl/mimo_tx_queue_scheduler_if.sv
// Reader-side virtual FIFO between the scheduler and the MIMO FIFO reader.
//   rd_pkt_waiting  scheduler -> reader  packet header visible
//   rd_fifodata     scheduler -> reader  data of the granted queue
//   rd_rdreq        reader -> scheduler  read request
//   rd_skip         reader -> scheduler  packet finished
// master = reader, slave = scheduler.
interface mimo_tx_queue_scheduler_if;
    import mimo_tx_pkg::*;

    logic        rd_pkt_waiting;
    logic [31:0] rd_fifodata;
    logic        rd_rdreq;
    logic        rd_skip;

    modport master (
        input  rd_pkt_waiting,
        input  rd_fifodata,
        output rd_rdreq,
        output rd_skip
    );

    modport slave (
        output rd_pkt_waiting,
        output rd_fifodata,
        input  rd_rdreq,
        input  rd_skip
    );

endinterface

// File: rtl/mimo_tx_queue_scheduler_arbiter.sv
// Combinational queue selector.
//   request     per-queue packet waiting
//   prio_mask   queues with strict priority (lowest index wins)
//   last_grant  index of the last completed queue; round-robin starts after it
//   select      one-hot chosen queue
//   valid       any request present
module tx_rr_prio_arbiter
    import mimo_tx_pkg::*;
#(
    parameter int unsigned NUM_Q = 2
) (
    input  logic [NUM_Q-1:0]         request,
    input  logic [NUM_Q-1:0]         prio_mask,
    input  logic [$clog2(NUM_Q)-1:0] last_grant,
    output logic [NUM_Q-1:0]         select,
    output logic                     valid
);

    logic [NUM_Q-1:0] prio_req;
    logic             found;
    int unsigned      idx;

    always_comb begin
        select   = '0;
        found    = 1'b0;
        idx      = 0;
        prio_req = request & prio_mask;
        if (|prio_req) begin
            for (int unsigned i = 0; i < NUM_Q; i++) begin
                if (!found && prio_req[i]) begin
                    select[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end else begin
            // Walk the ring starting one past the last grant.
            for (int unsigned k = 1; k <= NUM_Q; k++) begin
                idx = (32'(last_grant) + k) % NUM_Q;
                if (!found && request[idx]) begin
                    select[idx] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign valid = |request;

endmodule

// File: rtl/mimo_tx_queue_scheduler.sv
// Arbitrates NUM_Q host TX packet queues onto the single MIMO FIFO reader and
// presents the granted queue as one virtual FIFO. Grants last one packet, or a
// whole burst when the header opens one (sob without eob).
//   tx_clock, reset   clock, synchronous active-high reset
//   enable            permits new grants (a granted packet always completes)
//   prio_mask         queues with strict priority over round-robin
//   q_pkt_waiting     per-queue packet ready
//   q_fifodata        per-queue data, queue k at [32k+31:32k]
//   q_rdreq, q_skip   reader rdreq/skip routed to the granted queue
//   rd                reader-side virtual FIFO (slave modport)
//   grant             one-hot granted queue, 0 when none
//   busy              FSM not idle
//   lock_abort        one-cycle pulse when a burst lock times out
//   pkt_count         completed packets, wrapping
module mimo_tx_queue_scheduler
    import mimo_tx_pkg::*;
#(
    parameter int unsigned NUM_Q        = 2,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic                      tx_clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_Q-1:0]          prio_mask,
    input  logic [NUM_Q-1:0]          q_pkt_waiting,
    input  logic [32*NUM_Q-1:0]       q_fifodata,
    output logic [NUM_Q-1:0]          q_rdreq,
    output logic [NUM_Q-1:0]          q_skip,
    mimo_tx_queue_scheduler_if.slave  rd,
    output logic [NUM_Q-1:0]          grant,
    output logic                      busy,
    output logic                      lock_abort,
    output logic [15:0]               pkt_count
);

    localparam int unsigned QW = $clog2(NUM_Q);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;

    sched_state_t     state, state_n;
    logic [QW-1:0]    sel, sel_n;
    logic [QW-1:0]    last_grant, last_grant_n;
    logic [NUM_Q-1:0] grant_n;
    logic             lock, lock_n, lock_upd;
    logic             sob, sob_n, eob, eob_n;
    logic             pkt_waiting, pkt_waiting_n;
    logic             abort_n;
    logic [TW-1:0]    timer, timer_n;
    logic [15:0]      pkt_count_n;

    logic [NUM_Q-1:0] arb_select;
    logic             arb_valid;
    logic [QW-1:0]    arb_index;
    logic             route_en;
    logic [31:0]      rd_data;

    tx_rr_prio_arbiter #(
        .NUM_Q (NUM_Q)
    ) u_arbiter (
        .request    (q_pkt_waiting),
        .prio_mask  (prio_mask),
        .last_grant (last_grant),
        .select     (arb_select),
        .valid      (arb_valid)
    );

    always_comb begin
        arb_index = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            if (arb_select[i]) arb_index = QW'(i);
        end
    end

    // Routing is live only while a packet is presented to the reader.
    always_comb begin
        route_en = (state == PEEK) || (state == ACTIVE);
        rd_data  = '0;
        q_rdreq  = '0;
        q_skip   = '0;
        if (route_en) begin
            for (int unsigned i = 0; i < NUM_Q; i++) begin
                if (sel == QW'(i)) begin
                    rd_data    = q_fifodata[32*i +: 32];
                    q_rdreq[i] = rd.rd_rdreq;
                    q_skip[i]  = rd.rd_skip;
                end
            end
        end
    end

    assign rd.rd_fifodata    = rd_data;
    assign rd.rd_pkt_waiting = pkt_waiting;
    assign busy              = (state != IDLE);

    always_comb begin
        state_n       = state;
        sel_n         = sel;
        grant_n       = grant;
        last_grant_n  = last_grant;
        lock_n        = lock;
        sob_n         = sob;
        eob_n         = eob;
        pkt_waiting_n = pkt_waiting;
        abort_n       = 1'b0;
        timer_n       = timer;
        pkt_count_n   = pkt_count;
        lock_upd      = lock_next(lock, sob, eob);

        case (state)
            IDLE: begin
                if (enable && arb_valid) begin
                    sel_n   = arb_index;
                    grant_n = arb_select;
                    state_n = PEEK;
                end
            end
            PEEK: begin
                sob_n         = rd_data[HDR_SOB];
                eob_n         = rd_data[HDR_EOB];
                pkt_waiting_n = 1'b1;
                state_n       = ACTIVE;
            end
            ACTIVE: begin
                if (rd.rd_rdreq) pkt_waiting_n = 1'b0;
                if (rd.rd_skip) begin
                    pkt_waiting_n = 1'b0;
                    pkt_count_n   = pkt_count + 16'd1;
                    last_grant_n  = sel;
                    state_n       = RELEASE;
                end
            end
            RELEASE: begin
                // sob/eob are held while waiting here, so reapplying the
                // lock update every cycle gives the same result.
                lock_n = lock_upd;
                if (!lock_upd) begin
                    grant_n = '0;
                    timer_n = '0;
                    state_n = IDLE;
                end else if (q_pkt_waiting[sel]) begin
                    timer_n = '0;
                    state_n = PEEK;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    lock_n  = 1'b0;
                    abort_n = 1'b1;
                    grant_n = '0;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            grant       <= '0;
            last_grant  <= QW'(NUM_Q - 1);
            lock        <= 1'b0;
            sob         <= 1'b0;
            eob         <= 1'b0;
            pkt_waiting <= 1'b0;
            lock_abort  <= 1'b0;
            timer       <= '0;
            pkt_count   <= '0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            grant       <= grant_n;
            last_grant  <= last_grant_n;
            lock        <= lock_n;
            sob         <= sob_n;
            eob         <= eob_n;
            pkt_waiting <= pkt_waiting_n;
            lock_abort  <= abort_n;
            timer       <= timer_n;
            pkt_count   <= pkt_count_n;
        end
    end

endmodule

// File: tb/tb_mimo_tx_queue_scheduler.sv
// Testbench for mimo_tx_queue_scheduler: the bench plays both the host queues
// and the reader, predicting grant order, header, latency and lock aborts from
// a packet-level model of the queues.
module tb_mimo_tx_queue_scheduler;

    localparam int unsigned NUM_Q        = 2;
    localparam int unsigned LOCK_TIMEOUT = 8;

    logic                 tx_clock = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [NUM_Q-1:0]     prio_mask;
    logic [NUM_Q-1:0]     q_pkt_waiting;
    logic [32*NUM_Q-1:0]  q_fifodata;
    logic [NUM_Q-1:0]     q_rdreq;
    logic [NUM_Q-1:0]     q_skip;
    logic [NUM_Q-1:0]     grant;
    logic                 busy;
    logic                 lock_abort;
    logic [15:0]          pkt_count;

    mimo_tx_queue_scheduler_if rd_bus ();

    mimo_tx_queue_scheduler #(
        .NUM_Q        (NUM_Q),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .tx_clock      (tx_clock),
        .reset         (reset),
        .enable        (enable),
        .prio_mask     (prio_mask),
        .q_pkt_waiting (q_pkt_waiting),
        .q_fifodata    (q_fifodata),
        .q_rdreq       (q_rdreq),
        .q_skip        (q_skip),
        .rd            (rd_bus),
        .grant         (grant),
        .busy          (busy),
        .lock_abort    (lock_abort),
        .pkt_count     (pkt_count)
    );

    always #5 tx_clock = ~tx_clock;

    int checks   = 0;
    int failures = 0;

    // Packet-level model: per-queue packet lists plus scheduler bookkeeping.
    logic [31:0] pkt_mem [NUM_Q][16];
    int          pkt_head [NUM_Q];
    int          pkt_tail [NUM_Q];
    int          m_last;
    bit          m_lock;
    int          m_count;

    task automatic tick();
        @(posedge tx_clock);
        #1;
    endtask

    function automatic bit has_pkt(input int k);
        return pkt_tail[k] > pkt_head[k];
    endfunction

    function automatic logic [NUM_Q-1:0] oh(input int k);
        logic [NUM_Q-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mk_hdr(input bit sob, input bit eob);
        logic [31:0] w;
        w     = $urandom;
        w[28] = sob;
        w[27] = eob;
        return w;
    endfunction

    task automatic push(input int k, input logic [31:0] h);
        pkt_mem[k][pkt_tail[k]] = h;
        pkt_tail[k]++;
    endtask

    task automatic present();
        for (int k = 0; k < NUM_Q; k++) begin
            q_pkt_waiting[k]        = has_pkt(k);
            q_fifodata[32*k +: 32]  = has_pkt(k) ? pkt_mem[k][pkt_head[k]] : 32'h0;
        end
    endtask

    task automatic clear_queues();
        for (int k = 0; k < NUM_Q; k++) begin
            pkt_head[k] = 0;
            pkt_tail[k] = 0;
        end
        present();
    endtask

    // Strict priority first, otherwise the next waiting queue after the last one served.
    function automatic int pick();
        for (int i = 0; i < NUM_Q; i++)
            if (has_pkt(i) && prio_mask[i]) return i;
        for (int k = 1; k <= NUM_Q; k++)
            if (has_pkt((m_last + k) % NUM_Q)) return (m_last + k) % NUM_Q;
        return -1;
    endfunction

    task automatic do_reset();
        reset           = 1'b1;
        rd_bus.rd_rdreq = 1'b0;
        rd_bus.rd_skip  = 1'b0;
        clear_queues();
        tick();
        tick();
        reset   = 1'b0;
        m_last  = NUM_Q - 1;
        m_lock  = 1'b0;
        m_count = 0;
    endtask

    // Act as the reader until every modelled queue is drained. Latencies are
    // counted in clock edges from the cycle the queues were presented (first
    // packet) or from the cycle rd_skip was high.
    task automatic run_all();
        int lat, q, exp_lat, exp_abort_at, abort_at, abort_cnt, nreq;
        bit first;
        logic [31:0] hdr;
        lat   = 0;
        first = 1'b1;
        forever begin
            exp_abort_at = 0;
            if (first)                          exp_lat = 2;
            else if (m_lock && has_pkt(m_last)) exp_lat = 3;
            else if (m_lock) begin
                exp_lat      = 2 + LOCK_TIMEOUT + 1;
                exp_abort_at = LOCK_TIMEOUT + 1;
            end else                            exp_lat = 4;
            if (m_lock && !has_pkt(m_last)) m_lock = 1'b0;
            q = m_lock ? m_last : pick();
            abort_at  = 0;
            abort_cnt = 0;

            if (q < 0) begin
                while (lat < LOCK_TIMEOUT + 4) begin
                    tick();
                    lat++;
                    if (lock_abort === 1'b1) begin abort_at = lat; abort_cnt++; end
                end
                checks++;
                if (abort_at != exp_abort_at || abort_cnt != ((exp_abort_at != 0) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL end_abort: abort_at=%0d pulses=%0d expected at %0d", abort_at, abort_cnt, exp_abort_at);
                end
                checks++;
                if (grant !== '0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL end_idle: grant=%b busy=%b expected grant=0 busy=0", grant, busy);
                end
                return;
            end

            while (rd_bus.rd_pkt_waiting !== 1'b1 && lat < 40) begin
                tick();
                lat++;
                if (lock_abort === 1'b1) begin abort_at = lat; abort_cnt++; end
            end
            hdr = pkt_mem[q][pkt_head[q]];
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL latency: got %0d cycles expected %0d (queue %0d)", lat, exp_lat, q);
            end
            checks++;
            if (abort_at != exp_abort_at || abort_cnt != ((exp_abort_at != 0) ? 1 : 0)) begin
                failures++;
                $display("FAIL lock_abort: at=%0d pulses=%0d expected at %0d", abort_at, abort_cnt, exp_abort_at);
            end
            checks++;
            if (grant !== oh(q)) begin
                failures++;
                $display("FAIL grant: got %b expected %b", grant, oh(q));
            end
            checks++;
            if (rd_bus.rd_fifodata !== hdr) begin
                failures++;
                $display("FAIL header: got %h expected %h", rd_bus.rd_fifodata, hdr);
            end
            if (rd_bus.rd_pkt_waiting !== 1'b1) return;

            nreq = $urandom_range(0, 3);
            for (int r = 0; r < nreq; r++) begin
                rd_bus.rd_rdreq = 1'b1;
                #1;
                checks++;
                if (q_rdreq !== oh(q) || q_skip !== '0) begin
                    failures++;
                    $display("FAIL rdreq_route: q_rdreq=%b q_skip=%b expected %b/00", q_rdreq, q_skip, oh(q));
                end
                tick();
                if (r == 0) begin
                    checks++;
                    if (rd_bus.rd_pkt_waiting !== 1'b0) begin
                        failures++;
                        $display("FAIL pkt_waiting_clear: got %b expected 0", rd_bus.rd_pkt_waiting);
                    end
                end
            end

            rd_bus.rd_rdreq = 1'($urandom_range(0, 1));
            rd_bus.rd_skip  = 1'b1;
            #1;
            checks++;
            if (q_skip !== oh(q) || q_rdreq !== (rd_bus.rd_rdreq ? oh(q) : '0)) begin
                failures++;
                $display("FAIL skip_route: q_skip=%b q_rdreq=%b expected skip %b", q_skip, q_rdreq, oh(q));
            end
            tick();
            rd_bus.rd_skip  = 1'b0;
            rd_bus.rd_rdreq = 1'b0;
            pkt_head[q]++;
            present();
            if (hdr[28] && !hdr[27]) m_lock = 1'b1;
            else if (hdr[27])        m_lock = 1'b0;
            m_last  = q;
            m_count = (m_count + 1) & 16'hFFFF;
            checks++;
            if (pkt_count !== 16'(m_count) || rd_bus.rd_pkt_waiting !== 1'b0) begin
                failures++;
                $display("FAIL pkt_count: got %0d pw=%b expected %0d pw=0", pkt_count, rd_bus.rd_pkt_waiting, m_count);
            end
            first = 1'b0;
            lat   = 1;
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        enable          = 1'b1;
        prio_mask       = '0;
        clear_queues();
        push(0, mk_hdr(1, 1));
        present();
        rd_bus.rd_rdreq = 1'b1;
        rd_bus.rd_skip  = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || rd_bus.rd_pkt_waiting !== 1'b0 || lock_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b busy=%b pw=%b abort=%b expected all 0",
                     grant, busy, rd_bus.rd_pkt_waiting, lock_abort);
        end
        checks++;
        if (pkt_count !== 16'd0 || rd_bus.rd_fifodata !== 32'h0) begin
            failures++;
            $display("FAIL reset_count: pkt_count=%0d data=%h expected 0/0", pkt_count, rd_bus.rd_fifodata);
        end
        // Out of reset but disabled: reader strobes must not be routed.
        enable = 1'b0;
        reset  = 1'b0;
        tick();
        tick();
        checks++;
        if (q_rdreq !== '0 || q_skip !== '0 || grant !== '0) begin
            failures++;
            $display("FAIL idle_route: q_rdreq=%b q_skip=%b grant=%b expected 0", q_rdreq, q_skip, grant);
        end
        rd_bus.rd_rdreq = 1'b0;
        rd_bus.rd_skip  = 1'b0;
        enable          = 1'b1;
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        push(0, mk_hdr(1, 1));
        push(0, mk_hdr(1, 1));
        push(1, mk_hdr(1, 1));
        present();
        run_all();
    endtask

    task automatic test_priority();
        do_reset();
        prio_mask = 2'b10;
        for (int i = 0; i < 2; i++) push(0, mk_hdr(1, 1));
        for (int i = 0; i < 3; i++) push(1, mk_hdr(1, 1));
        present();
        run_all();
        prio_mask = '0;
    endtask

    task automatic test_burst_lock();
        do_reset();
        push(0, mk_hdr(1, 0));
        push(0, mk_hdr(0, 0));
        push(0, mk_hdr(0, 1));
        push(1, mk_hdr(1, 1));
        present();
        run_all();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        push(0, mk_hdr(1, 0));
        push(1, mk_hdr(1, 1));
        present();
        run_all();
    endtask

    task automatic test_enable_hold();
        int n;
        do_reset();
        push(0, mk_hdr(1, 1));
        push(1, mk_hdr(1, 1));
        present();
        n = 0;
        while (rd_bus.rd_pkt_waiting !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 2 || grant !== 2'b01) begin
            failures++;
            $display("FAIL enable_first: latency=%0d grant=%b expected 2/01", n, grant);
        end
        enable         = 1'b0;
        rd_bus.rd_skip = 1'b1;
        #1;
        checks++;
        if (q_skip !== 2'b01) begin
            failures++;
            $display("FAIL enable_skip_route: got %b expected 01", q_skip);
        end
        tick();
        rd_bus.rd_skip = 1'b0;
        pkt_head[0]++;
        present();
        m_last  = 0;
        m_count = m_count + 1;
        checks++;
        if (pkt_count !== 16'(m_count)) begin
            failures++;
            $display("FAIL enable_count: got %0d expected %0d", pkt_count, m_count);
        end
        repeat (6) tick();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || q_pkt_waiting !== 2'b10) begin
            failures++;
            $display("FAIL enable_hold: grant=%b busy=%b expected grant=0 busy=0", grant, busy);
        end
        enable = 1'b1;
        run_all();
    endtask

    task automatic test_reset_mid_packet();
        int n;
        clear_queues();
        push(0, mk_hdr(1, 1));
        present();
        n = 0;
        while (rd_bus.rd_pkt_waiting !== 1'b1 && n < 20) begin tick(); n++; end
        rd_bus.rd_rdreq = 1'b1;
        #1;
        checks++;
        if (q_rdreq !== 2'b01) begin
            failures++;
            $display("FAIL midreset_route: got %b expected 01", q_rdreq);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || q_rdreq !== '0 || q_skip !== '0 || rd_bus.rd_pkt_waiting !== 1'b0 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL midreset_state: grant=%b q_rdreq=%b q_skip=%b pw=%b count=%0d expected all 0",
                     grant, q_rdreq, q_skip, rd_bus.rd_pkt_waiting, pkt_count);
        end
        rd_bus.rd_rdreq = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        int n, total, r;
        for (int round = 0; round < 8; round++) begin
            clear_queues();
            prio_mask = NUM_Q'($urandom_range(0, 3));
            total = 0;
            for (int k = 0; k < NUM_Q; k++) begin
                n = $urandom_range(0, 4);
                for (int i = 0; i < n; i++) begin
                    r = $urandom_range(0, 3);
                    push(k, mk_hdr(r <= 1, (r == 0) || (r == 3)));
                end
                total += n;
            end
            if (total == 0) push(1, mk_hdr(1, 1));
            present();
            run_all();
        end
        prio_mask = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        enable          = 1'b0;
        prio_mask       = '0;
        q_pkt_waiting   = '0;
        q_fifodata      = '0;
        rd_bus.rd_rdreq = 1'b0;
        rd_bus.rd_skip  = 1'b0;
        m_last          = NUM_Q - 1;
        m_lock          = 1'b0;
        m_count         = 0;
        tick();
        test_reset();
        test_round_robin();
        test_priority();
        test_burst_lock();
        test_lock_timeout();
        test_enable_hold();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
